// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: PC advance/hold/redirect, F/D and D/E bubble control.
// Optional perf counters are built only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
  parameter int INST_SIZE = 32,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_taken_ex,
  input  logic [INST_SIZE-1:0] br_base_ex,
  input  logic [INST_SIZE-1:0] br_disp_ex,
  input  logic                 hazard_stall,
  input  logic                 imem_ready,
  output logic                 imem_req,
  output logic                 pc_en,
  output logic                 pc_r,
  output logic [INST_SIZE-1:0] pc_ex,
  output logic [INST_SIZE-1:0] pc_disp,
  output logic                 fd_stall,
  output logic                 fd_flush,
  output logic                 de_flush,
  output logic [CNT_W-1:0]     perf_redirects,
  output logic [CNT_W-1:0]     perf_stalls
);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, REDIR_PEND} state_e;

  state_e               state_q, state_d;
  logic [INST_SIZE-1:0] base_q, base_d;
  logic [INST_SIZE-1:0] disp_q, disp_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      base_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    disp_d   = disp_q;
    imem_req = 1'b0;
    pc_en    = 1'b0;
    pc_r     = 1'b0;
    pc_ex    = '0;
    pc_disp  = '0;
    fd_stall = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    if (!rst) begin
      unique case (state_q)
        BOOT: begin
          fd_flush = 1'b1;
          state_d  = RUN;
        end
        RUN, MEM_WAIT: begin
          imem_req = 1'b1;
          if (br_taken_ex) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            if (imem_ready) begin
              pc_r    = 1'b1;
              pc_ex   = br_base_ex;
              pc_disp = br_disp_ex;
              pc_en   = 1'b1;
              state_d = RUN;
            end else begin
              // Redirect must wait until the in-flight fetch drains.
              base_d  = br_base_ex;
              disp_d  = br_disp_ex;
              state_d = REDIR_PEND;
            end
          end else if (!imem_ready) begin
            fd_flush = 1'b1;
            state_d  = MEM_WAIT;
          end else if (hazard_stall) begin
            fd_stall = 1'b1;
            state_d  = RUN;
          end else begin
            pc_en   = 1'b1;
            state_d = RUN;
          end
        end
        REDIR_PEND: begin
          // The word returned here is wrong-path, so F/D stays flushed.
          imem_req = 1'b1;
          fd_flush = 1'b1;
          if (imem_ready) begin
            pc_r    = 1'b1;
            pc_ex   = base_q;
            pc_disp = disp_q;
            pc_en   = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] redir_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      redir_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pc_r && !(&redir_cnt_q))
        redir_cnt_q <= redir_cnt_q + CNT_ONE;
      if ((state_q != BOOT) && !pc_en && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign perf_redirects = rst ? '0 : redir_cnt_q;
  assign perf_stalls    = rst ? '0 : stall_cnt_q;
`else
  assign perf_redirects = '0;
  assign perf_stalls    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed test-plan sequence followed by
// randomized cycles, compared against a rule-level reference model.
module tb_fetch_ctrl;
  localparam int IW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_taken_ex;
  logic [IW-1:0] br_base_ex;
  logic [IW-1:0] br_disp_ex;
  logic          hazard_stall;
  logic          imem_ready;
  logic          imem_req;
  logic          pc_en;
  logic          pc_r;
  logic [IW-1:0] pc_ex;
  logic [IW-1:0] pc_disp;
  logic          fd_stall;
  logic          fd_flush;
  logic          de_flush;
  logic [CW-1:0] perf_redirects;
  logic [CW-1:0] perf_stalls;

  always #5 clk = ~clk;

  fetch_ctrl #(.INST_SIZE(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .br_taken_ex(br_taken_ex), .br_base_ex(br_base_ex), .br_disp_ex(br_disp_ex),
    .hazard_stall(hazard_stall), .imem_ready(imem_ready),
    .imem_req(imem_req), .pc_en(pc_en), .pc_r(pc_r),
    .pc_ex(pc_ex), .pc_disp(pc_disp),
    .fd_stall(fd_stall), .fd_flush(fd_flush), .de_flush(de_flush),
    .perf_redirects(perf_redirects), .perf_stalls(perf_stalls)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_no   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc_no, obs, exp);
  endtask

  // Reference model: "just left reset", "redirect owed" with its operands, event counts.
  bit            m_boot = 1'b1;
  bit            m_pend = 1'b0;
  logic [IW-1:0] m_base = '0;
  logic [IW-1:0] m_disp = '0;
  longint        m_redir = 0;
  longint        m_stall = 0;

  function automatic logic [CW-1:0] sat(input longint v);
    longint maxv = (longint'(1) << CW) - 1;
    return (v > maxv) ? CW'(maxv) : CW'(v);
  endfunction

  task automatic cyc(input bit r, input bit b, input logic [IW-1:0] bb, input logic [IW-1:0] bd,
                     input bit h, input bit rd);
    bit e_req, e_en, e_r, e_st, e_ff, e_df;
    logic [IW-1:0] e_ex, e_disp;
    logic [CW-1:0] e_pr, e_ps;
    rst = r; br_taken_ex = b; br_base_ex = bb; br_disp_ex = bd;
    hazard_stall = h; imem_ready = rd;
    e_req = 0; e_en = 0; e_r = 0; e_st = 0; e_ff = 0; e_df = 0;
    e_ex = '0; e_disp = '0;
    if (r) begin
    end else if (m_boot) begin
      e_ff = 1;
    end else if (m_pend) begin
      e_req = 1; e_ff = 1;
      if (rd) begin e_r = 1; e_ex = m_base; e_disp = m_disp; e_en = 1; end
    end else begin
      e_req = 1;
      if (b) begin
        e_ff = 1; e_df = 1;
        if (rd) begin e_r = 1; e_ex = bb; e_disp = bd; e_en = 1; end
      end else if (!rd) e_ff = 1;
      else if (h) e_st = 1;
      else e_en = 1;
    end
`ifdef FETCH_CTRL_PERF_EN
    e_pr = r ? '0 : sat(m_redir);
    e_ps = r ? '0 : sat(m_stall);
`else
    e_pr = '0;
    e_ps = '0;
`endif
    @(negedge clk);
    check("flags{req,en,r,stall,fflush,dflush}",
          64'({imem_req, pc_en, pc_r, fd_stall, fd_flush, de_flush}),
          64'({e_req, e_en, e_r, e_st, e_ff, e_df}));
    check("pc_ex", 64'(pc_ex), 64'(e_ex));
    check("pc_disp", 64'(pc_disp), 64'(e_disp));
    check("perf_redirects", 64'(perf_redirects), 64'(e_pr));
    check("perf_stalls", 64'(perf_stalls), 64'(e_ps));
    @(posedge clk);
    if (r) begin
      m_boot = 1; m_pend = 0; m_redir = 0; m_stall = 0;
    end else begin
      if (e_r) m_redir++;
      if (!m_boot && !e_en) m_stall++;
      if (m_pend) begin
        if (rd) m_pend = 0;
      end else if (!m_boot && b && !rd) begin
        m_pend = 1; m_base = bb; m_disp = bd;
      end
      m_boot = 0;
    end
    cyc_no++;
    #1;
  endtask

  initial begin
    rst = 1; br_taken_ex = 0; br_base_ex = '0; br_disp_ex = '0;
    hazard_stall = 0; imem_ready = 1;
    repeat (3) cyc(1, 0, 0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h100, 32'h20, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h40, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 1, 32'h999, 32'h4, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'h80, 32'h8, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 6) == 0), $urandom, $urandom,
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the fetch stage.
- Decides each cycle whether the PC advances, holds or takes an EX-resolved redirect.
- Drives the fetch-stage redirect select and operands (PC_R, PC_EX, PC_DISP), and the instruction-memory request.
- Generates hold/bubble controls for the F/D and D/E pipeline registers, and tolerates variable instruction-memory latency through a req/ready handshake.

Parameters:
- INST_SIZE, 32, width of PC, target and displacement.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- br_taken_ex  in  1  EX resolved a taken branch/jump this cycle.
- br_base_ex  in  INST_SIZE  redirect base PC from EX.
- br_disp_ex  in  INST_SIZE  redirect displacement from EX.
- hazard_stall  in  1  decode load-use hazard; hold fetch.
- imem_ready  in  1  instruction word for current PC is valid this cycle.
- imem_req  out  1  fetch request for current PC.
- pc_en  out  1  PC register update enable.
- pc_r  out  1  redirect select to fetch muxes (1 = base+disp).
- pc_ex  out  INST_SIZE  redirect base to fetch adder.
- pc_disp  out  INST_SIZE  redirect displacement to fetch adder.
- fd_stall  out  1  hold F/D register.
- fd_flush  out  1  load NOP/zero into F/D register.
- de_flush  out  1  load NOP/zero into D/E register.
- perf_redirects  out  CNT_W  redirect count (optional feature).
- perf_stalls  out  CNT_W  non-advancing cycle count (optional feature).

Behaviour:
- State register: BOOT, RUN, MEM_WAIT, REDIR_PEND.
  - Capture registers: base_q, disp_q.
  - Outputs are Mealy, combinational from state and inputs; no added latency.
- Reset (sync, rst=1 at posedge):
  - state=BOOT; base_q=disp_q=0; counters=0.
  - While rst=1, all outputs are 0.
  - Reset mid-operation discards any pending redirect.
- BOOT:
  - Lasts exactly one cycle after rst falls.
  - imem_req=0, pc_en=0, fd_flush=1, other outputs 0.
  - Next state: RUN.
- RUN and MEM_WAIT: imem_req=1. Priority is br_taken_ex > imem_ready=0 > hazard_stall.
  - br_taken_ex=1 and imem_ready=1:
    - pc_r=1, pc_ex=br_base_ex, pc_disp=br_disp_ex, pc_en=1.
    - fd_flush=1, de_flush=1.
    - Next state: RUN. The PC holds base+disp after the edge.
  - br_taken_ex=1 and imem_ready=0:
    - Capture base_q/disp_q; pc_en=0; pc_r=0.
    - fd_flush=1, de_flush=1.
    - Next state: REDIR_PEND.
  - imem_ready=0 (no branch):
    - pc_en=0, fd_flush=1 (bubble).
    - Next state: MEM_WAIT.
  - hazard_stall=1 (ready, no branch):
    - pc_en=0, fd_stall=1, fd_flush=0.
    - Next state: RUN.
  - Otherwise:
    - pc_en=1, pc_r=0; fetch mux adds the increment.
    - Next state: RUN.
- REDIR_PEND (stale in-flight fetch must complete before redirect):
  - imem_req=1, fd_flush=1, pc_r=0, pc_en=0 while imem_ready=0.
  - On imem_ready=1: pc_r=1, pc_ex=base_q, pc_disp=disp_q, pc_en=1. Next state: RUN.
  - br_taken_ex and hazard_stall are ignored in this state (pipeline already flushed).
- pc_ex/pc_disp are 0 whenever pc_r=0.
- Flush wins over stall: fd_stall and fd_flush are never both 1.
- Width rule: no arithmetic here; the adder lives in the fetch stage and wraps modulo 2^INST_SIZE.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- Defined:
  - perf_redirects increments on each cycle with pc_r=1.
  - perf_stalls increments on each cycle in RUN/MEM_WAIT/REDIR_PEND with pc_en=0.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- rst=1 for 3 cycles, then release with imem_ready=1:
  - All outputs are 0 during reset.
  - Cycle 1 after release: BOOT, pc_en=0, fd_flush=1.
  - From cycle 2: pc_en=1 every cycle with pc_r=0.
- Steady RUN, pulse hazard_stall for 2 cycles:
  - pc_en=0 and fd_stall=1 for exactly those 2 cycles; no flush.
- br_taken_ex=1, base=0x100, disp=0x20, imem_ready=1:
  - Same cycle: pc_r=1, pc_ex=0x100, pc_disp=0x20, fd_flush=de_flush=1.
  - Next cycle: pc_r=0.
- br_taken_ex=1 (base=0x40, disp=0xFFFFFFFC) with imem_ready=0 for 3 cycles:
  - Cycles 1–3: de_flush=1 in cycle 1 only, fd_flush=1 throughout, pc_en=0.
  - Cycle 4 (ready=1): pc_r=1, pc_ex=0x40, pc_disp=0xFFFFFFFC, pc_en=1.
  - A second br_taken_ex in cycle 2 is ignored.
- imem_ready=0 for 2 cycles together with hazard_stall=1:
  - fd_flush=1, fd_stall=0, pc_en=0 for both cycles; resumes in RUN.
- Assert rst while in REDIR_PEND:
  - Next cycle all outputs are 0.
  - After release, BOOT then sequential fetch with no redirect.
  - With FETCH_CTRL_PERF_EN, both counters read 0.
